iterative_divider: RTL and testbench

// - Multi-cycle RV32M DIV/DIVU/REM/REMU unit in the EXE stage; restoring radix-2, one quotient bit per cycle.
// - Produces divide_stall, which freezes IF/ID, ID/EXE and EXE/MEM in the pipeline controller while a division runs.
// - Produces the final result for the EXE-stage result mux.

---
 rtl/iterative_divider_pkg.sv | 28 ++
 rtl/div_sign_fixup.sv | 31 +++
 rtl/iterative_divider.sv | 132 +++++++++++++
 tb/tb_iterative_divider.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package iterative_divider_pkg;

  localparam int XLEN = 32;

  // Encoding matches funct3[1:0] of the M-extension divide group.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic op_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// Turns unsigned quotient/remainder magnitudes into the architectural result,
// applying sign fixups and the divide-by-zero / signed-overflow overrides.
module div_sign_fixup
  import iterative_divider_pkg::*;
(
  input  logic            is_rem,
  input  logic            neg_quo,
  input  logic            neg_rem,
  input  logic            spec_zero,
  input  logic            spec_ovf,
  input  logic [XLEN-1:0] quo_mag,
  input  logic [XLEN-1:0] rem_mag,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;

  always_comb begin
    quo_s = neg_quo ? -quo_mag : quo_mag;
    rem_s = neg_rem ? -rem_mag : rem_mag;
    // rem_mag holds |dividend| on divide-by-zero, so rem_s already equals dividend
    if (spec_zero) quo_s = '1;
    if (spec_ovf) begin
      quo_s = {1'b1, {(XLEN-1){1'b0}}};
      rem_s = '0;
    end
    result = is_rem ? rem_s : quo_s;
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient
// bit per cycle, with a pipeline stall output and kill/hold handshake.
module iterative_divider
  import iterative_divider_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            div_start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  input  logic            hold,
  output logic            divide_stall,
  output logic [XLEN-1:0] div_result,
  output logic            div_done
);

  localparam int CNT_W = $clog2(XLEN + 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  div_op_e          op_q;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dsr_mag;
  logic             neg_quo;
  logic             neg_rem;
  logic             spec_zero;
  logic             spec_ovf;

  // operand decode at accept time
  div_op_e         op_in;
  logic            sgn_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            zero_in;
  logic            ovf_in;
  logic            accept;

  always_comb begin
    op_in   = div_op_e'(div_op);
    sgn_in  = op_signed(op_in);
    a_neg   = sgn_in & dividend[XLEN-1];
    b_neg   = sgn_in & divisor[XLEN-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    zero_in = (divisor == '0);
    ovf_in  = sgn_in && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  end

  assign accept = reset_n && (state == IDLE) && div_start && !kill;

  // Partial remainder is one bit wider so DIVU with divisor >= 2^(XLEN-1) stays exact.
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] rem_sub;
  logic          ge;

  assign rem_sh  = {rem, quo[XLEN-1]};
  assign rem_sub = rem_sh - {1'b0, dsr_mag};
  assign ge      = (rem_sh >= {1'b0, dsr_mag});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= DIV;
      quo       <= '0;
      rem       <= '0;
      dsr_mag   <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      spec_zero <= 1'b0;
      spec_ovf  <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          op_q      <= op_in;
          dsr_mag   <= b_mag;
          neg_quo   <= (a_neg ^ b_neg) && !zero_in;
          neg_rem   <= a_neg;
          spec_zero <= zero_in;
          spec_ovf  <= ovf_in;
          if (zero_in || ovf_in) begin
            state <= DONE;
            quo   <= '0;
            rem   <= a_mag;
          end else begin
            state <= BUSY;
            cnt   <= CNT_W'(XLEN);
            quo   <= a_mag;
            rem   <= '0;
          end
        end
        BUSY: begin
          quo <= {quo[XLEN-2:0], ge};
          rem <= ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: if (!hold) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [XLEN-1:0] fix_result;
  logic            is_rem;

  assign is_rem = op_rem(op_q);

  div_sign_fixup u_fixup (
    .is_rem   (is_rem),
    .neg_quo  (neg_quo),
    .neg_rem  (neg_rem),
    .spec_zero(spec_zero),
    .spec_ovf (spec_ovf),
    .quo_mag  (quo),
    .rem_mag  (rem),
    .result   (fix_result)
  );

  assign divide_stall = accept || (reset_n && !kill && (state == BUSY));
  assign div_done     = (state == DONE) && !kill;
  assign div_result   = div_done ? fix_result : '0;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench: directed corner cases plus random ops against an
// arithmetic reference model of RV32M division.
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            div_start;
  logic [1:0]      div_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            kill;
  logic            hold;
  logic            divide_stall;
  logic [XLEN-1:0] div_result;
  logic            div_done;

  int checks = 0;
  int errors = 0;

  iterative_divider dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .div_start   (div_start),
    .div_op      (div_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .kill        (kill),
    .hold        (hold),
    .divide_stall(divide_stall),
    .div_result  (div_result),
    .div_done    (div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '1; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 0;
    end else if (!op[0]) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Called just after a rising edge with the DUT in IDLE; returns just after
  // the edge that leaves DONE, with div_start dropped.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold_n);
    int stalls;
    bit got;
    logic [31:0] exp;
    exp    = ref_res(op, a, b);
    stalls = 0;
    got    = 0;
    div_start = 1'b1; div_op = op; dividend = a; divisor = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (i == 0) chk("accept_stall", {31'b0, divide_stall}, 32'd1);
      if (div_done) got = 1;
      else if (divide_stall) stalls++;
      if (!got) begin
        @(posedge clk); #1;
        dividend = $urandom; divisor = $urandom;
      end
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    chk("stall_cycles", stalls, is_fast(op, a, b) ? 32'd1 : 32'(XLEN + 1));
    chk("result", div_result, exp);
    chk("stall_in_done", {31'b0, divide_stall}, 32'd0);
    hold = (hold_n > 0);
    for (int h = 0; h < hold_n; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_done", {31'b0, div_done}, 32'd1);
      chk("hold_result", div_result, exp);
      hold = (h + 1 < hold_n);
    end
    @(posedge clk); #1;
    div_start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; div_start = 1'b0; div_op = 2'b00;
    dividend = '0; divisor = '0; kill = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'b0, divide_stall}, 32'd0);
    chk("rst_done", {31'b0, div_done}, 32'd0);
    chk("rst_result", div_result, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    do_div(DIV,  32'hFFFF_FFF9, 32'd2, 0);
    do_div(REM,  32'hFFFF_FFF9, 32'd2, 0);
    do_div(DIVU, 32'hFFFF_FFFF, 32'd16, 0);
    do_div(REMU, 32'hFFFF_FFFF, 32'd16, 0);
    do_div(DIV,  32'd5, 32'd0, 0);
    do_div(REM,  32'd5, 32'd0, 0);
    do_div(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(DIVU, 32'h8000_0001, 32'hFFFF_FFFF, 0);
    do_div(REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);

    // hold in DONE, then back-to-back accept in the following IDLE cycle
    do_div(DIV, 32'd100, 32'hFFFF_FFF7, 3);
    do_div(DIV, 32'hFFFF_FFCE, 32'd7, 0);

    // kill at BUSY cycle 10
    div_start = 1'b1; div_op = DIV; dividend = 32'd1000; divisor = 32'd3;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    chk("kill_stall", {31'b0, divide_stall}, 32'd0);
    chk("kill_done", {31'b0, div_done}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; div_start = 1'b0;
    @(negedge clk);
    chk("post_kill_idle", {31'b0, divide_stall | div_done}, 32'd0);
    @(posedge clk); #1;
    do_div(DIVU, 32'd100, 32'd7, 0);

    // kill overrides div_start in IDLE
    div_start = 1'b1; kill = 1'b1; div_op = DIVU; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    chk("kill_vs_start", {31'b0, divide_stall}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; div_start = 1'b0;
    @(negedge clk);
    chk("kill_no_accept", {31'b0, divide_stall | div_done}, 32'd0);

    // kill while in DONE suppresses div_done
    @(posedge clk); #1;
    div_start = 1'b1; div_op = DIV; dividend = 32'd5; divisor = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_before_kill", {31'b0, div_done}, 32'd1);
    kill = 1'b1;
    #1 chk("kill_in_done", {31'b0, div_done}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; div_start = 1'b0;
    @(negedge clk);
    chk("kill_done_idle", {31'b0, div_done}, 32'd0);
    @(posedge clk); #1;

    // reset mid-BUSY
    div_start = 1'b1; div_op = DIVU; dividend = 32'd12345; divisor = 32'd17;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_stall", {31'b0, divide_stall}, 32'd0);
    chk("rst_mid_done", {31'b0, div_done}, 32'd0);
    chk("rst_mid_result", div_result, 32'd0);
    div_start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_div(REMU, 32'd12345, 32'd17, 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 15);
        4:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_div(op, a, b, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
